// File: rtl/buzzer_key_ctrl_if.sv
// ----------------------------------------------------------------------------
// buzzer_key_ctrl_if
//
// Bundles the key-event inputs and the buzzer/status outputs of
// buzzer_key_ctrl.
//
//   key_flag   one-cycle strobe, key_value valid and stable
//   key_value  3 debounced key levels, 0 = pressed
//   beep       PWM drive to the passive buzzer, 1 = driven
//   playing    1 while the controller is in PLAY
//   tone_idx   current tone 0..6 (C4..B4)
//   duty_sel   current duty (volume) level 0..3
//
// master: the key source side (debouncer or bench).
// slave : the controller side.
// ----------------------------------------------------------------------------
interface buzzer_key_ctrl_if;
    logic       key_flag;
    logic [2:0] key_value;
    logic       beep;
    logic       playing;
    logic [2:0] tone_idx;
    logic [1:0] duty_sel;

    modport master (
        output key_flag, key_value,
        input  beep, playing, tone_idx, duty_sel
    );

    modport slave (
        input  key_flag, key_value,
        output beep, playing, tone_idx, duty_sel
    );
endinterface

// File: rtl/buzzer_key_ctrl.sv
// ----------------------------------------------------------------------------
// buzzer_key_ctrl
//
// Key-driven PWM buzzer controller. It sits between the key debouncer and the
// buzzer pad. Each debounced key event does one of the following:
//   - toggles play/stop,
//   - steps the duty level (volume),
//   - steps the tone through C4..B4.
// While playing, a PWM square wave at the selected tone is driven on beep.
// Playback stops by itself after PLAY_MS milliseconds without a key event.
//
// Parameters
//   CLK_FREQ  clk frequency in Hz; the tone periods and the ms prescaler
//             are derived from it
//   PLAY_MS   auto-stop timeout in ms (16-bit); 0 disables the timeout
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    buzzer_key_ctrl_if.slave
//            inputs : key_flag, key_value
//            outputs: beep, playing, tone_idx, duty_sel
// ----------------------------------------------------------------------------
module buzzer_key_ctrl #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned PLAY_MS  = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    buzzer_key_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // The lowest tone (C4, 262 Hz) has the longest period, so it sets the
    // counter width. The counter is never narrower than 18 bits.
    localparam int unsigned P_MAX   = CLK_FREQ / 262;
    localparam int          CNT_W   = ($clog2(P_MAX + 1) > 18) ? $clog2(P_MAX + 1) : 18;

    localparam int unsigned MS_DIV  = ((CLK_FREQ / 1000) > 0) ? (CLK_FREQ / 1000) : 1;
    localparam int          PRE_W   = ($clog2(MS_DIV) > 0) ? $clog2(MS_DIV) : 1;

    localparam logic [15:0] PLAY_MS_W  = 16'(PLAY_MS);
    localparam bit          TIMEOUT_EN = (PLAY_MS != 0);

    // Tone periods in clk cycles: CLK_FREQ / f, using integer division.
    localparam logic [CNT_W-1:0] P_C4 = CNT_W'(CLK_FREQ / 262);
    localparam logic [CNT_W-1:0] P_D4 = CNT_W'(CLK_FREQ / 294);
    localparam logic [CNT_W-1:0] P_E4 = CNT_W'(CLK_FREQ / 330);
    localparam logic [CNT_W-1:0] P_F4 = CNT_W'(CLK_FREQ / 349);
    localparam logic [CNT_W-1:0] P_G4 = CNT_W'(CLK_FREQ / 392);
    localparam logic [CNT_W-1:0] P_A4 = CNT_W'(CLK_FREQ / 440);
    localparam logic [CNT_W-1:0] P_B4 = CNT_W'(CLK_FREQ / 494);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;

    logic [2:0]        tone_idx;
    logic [2:0]        tone_nxt;
    logic [1:0]        duty_sel;
    logic [1:0]        duty_nxt;

    logic              key_evt;
    logic              play_evt;
    logic              duty_evt;
    logic              tone_evt;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  p_act;
    logic [CNT_W-1:0]  c_act;
    logic [CNT_W-1:0]  p_tab;
    logic [CNT_W-1:0]  c_tab;
    logic [2:0]        duty_shift;
    logic              beep;

    logic [PRE_W-1:0]  pre;
    logic [15:0]       ms_cnt;
    logic              timeout;
    logic              timer_clr;

    logic              enter_play;
    logic              stay_play;
    logic              wrap;

    // ------------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------------
    // Key values are only meaningful on key_flag. The all-released pattern is
    // the release edge of a key and carries no action. When several keys are
    // pressed at once, only one action is taken: key[2] > key[1] > key[0].
    assign key_evt  = bus.key_flag && (bus.key_value != 3'b111);
    assign play_evt = key_evt && !bus.key_value[2];
    assign duty_evt = key_evt &&  bus.key_value[2] && !bus.key_value[1];
    assign tone_evt = key_evt &&  bus.key_value[2] &&  bus.key_value[1] && !bus.key_value[0];

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        tone_nxt = tone_idx;
        duty_nxt = duty_sel;
        if (tone_evt) begin
            tone_nxt = (tone_idx == 3'd6) ? 3'd0 : tone_idx + 3'd1;
        end
        if (duty_evt) begin
            duty_nxt = duty_sel + 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // The timeout fires once ms_cnt reaches PLAY_MS. If a stop key and the
    // timeout happen in the same cycle, the result is still a single
    // transition to IDLE.
    assign timeout = TIMEOUT_EN && (state == PLAY) && (ms_cnt == PLAY_MS_W);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (play_evt)             state_nxt = PLAY;
            PLAY:    if (play_evt || timeout)  state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments, so every
            // clocked block samples the values from before the edge.
            state    <= IDLE;
            tone_idx <= 3'd0;
            duty_sel <= 2'd0;
        end else begin
            state    <= state_nxt;
            tone_idx <= tone_nxt;
            duty_sel <= duty_nxt;
        end
    end

    assign enter_play = (state == IDLE) && (state_nxt == PLAY);
    assign stay_play  = (state == PLAY) && (state_nxt == PLAY);
    assign wrap       = (cnt == p_act - CNT_W'(1));

    // ------------------------------------------------------------------------
    // Tone / duty table
    // ------------------------------------------------------------------------
    // The lookup uses the post-event selections. A key event that lands
    // exactly on a period boundary therefore already shapes the period that
    // begins at that edge.
    always_comb begin
        unique case (tone_nxt)
            3'd0:    p_tab = P_C4;
            3'd1:    p_tab = P_D4;
            3'd2:    p_tab = P_E4;
            3'd3:    p_tab = P_F4;
            3'd4:    p_tab = P_G4;
            3'd5:    p_tab = P_A4;
            default: p_tab = P_B4;
        endcase
        // The shift is widened before the +1, so that duty level 3 shifts
        // by 4 instead of wrapping to a shift of 0.
        duty_shift = {1'b0, duty_nxt} + 3'd1;
        c_tab      = p_tab >> duty_shift;
    end

    // ------------------------------------------------------------------------
    // PWM
    // ------------------------------------------------------------------------
    // p_act/c_act are shadow copies of the table. They reload only when PLAY
    // is entered and at each period wrap. A tone or duty change in the middle
    // of a period never produces a short period or a glitch on beep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            p_act <= '0;
            c_act <= '0;
            beep  <= 1'b0;
        end else begin
            beep <= (state == PLAY) && (cnt < c_act);

            if (enter_play || (stay_play && wrap)) begin
                p_act <= p_tab;
                c_act <= c_tab;
            end

            if (stay_play && !wrap) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Auto-stop timer
    // ------------------------------------------------------------------------
    // The timer restarts whenever the player shows activity: entering PLAY,
    // or an accepted tone/duty event while playing. It is held at zero
    // outside PLAY.
    assign timer_clr = (state_nxt != PLAY) || enter_play ||
                       ((state == PLAY) && (duty_evt || tone_evt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (timer_clr) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (pre == PRE_W'(MS_DIV - 1)) begin
            pre    <= '0;
            ms_cnt <= ms_cnt + 16'd1;
        end else begin
            pre    <= pre + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.beep     = beep;
    assign bus.playing  = (state == PLAY);
    assign bus.tone_idx = tone_idx;
    assign bus.duty_sel = duty_sel;

endmodule

// File: tb/tb_buzzer_key_ctrl.sv
// ----------------------------------------------------------------------------
// tb_buzzer_key_ctrl
//
// Self-checking bench for buzzer_key_ctrl. It runs with a reduced clock
// frequency so that the tone periods and the timeout stay short.
//
// A reference model tracks the player at the level of the rules:
//   - play state, tone and duty,
//   - the position inside the current beep period,
//   - the cycles elapsed since the last activity.
// The model is compared with the DUT on every falling edge. Directed
// sections also measure beep periods, high times and the timeout delay
// directly from the waveform.
// ----------------------------------------------------------------------------
module tb_buzzer_key_ctrl;

    localparam int unsigned CLK_FREQ = 200_000;
    localparam int unsigned PLAY_MS  = 20;
    localparam int unsigned MS_DIV   = CLK_FREQ / 1000;
    localparam int unsigned T_OUT    = PLAY_MS * MS_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int   n_checks = 0;
    int   n_pass   = 0;

    buzzer_key_ctrl_if bus();

    buzzer_key_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .PLAY_MS  (PLAY_MS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int tone_hz(input int t);
        case (t)
            0: return 262;
            1: return 294;
            2: return 330;
            3: return 349;
            4: return 392;
            5: return 440;
            default: return 494;
        endcase
    endfunction

    function automatic int period_of(input int t);
        return CLK_FREQ / tone_hz(t);
    endfunction

    function automatic int high_of(input int t, input int d);
        return period_of(t) >> (d + 1);
    endfunction

    bit m_play, m_beep, model_on;
    int m_tone, m_duty, m_phase, m_p, m_c, m_age;

    task automatic model_step();
        bit old_play, play_e, duty_e, tone_e, tmo;
        if (!rst_n) begin
            m_play = 0; m_beep = 0; m_tone = 0; m_duty = 0;
            m_phase = 0; m_p = 0; m_c = 0; m_age = 0;
            return;
        end
        old_play = m_play;
        m_beep   = old_play && (m_phase < m_c);
        play_e = 0; duty_e = 0; tone_e = 0;
        if (bus.key_flag && bus.key_value != 3'b111) begin
            if (!bus.key_value[2])      play_e = 1;
            else if (!bus.key_value[1]) duty_e = 1;
            else                        tone_e = 1;
        end
        if (duty_e) m_duty = (m_duty + 1) % 4;
        if (tone_e) m_tone = (m_tone + 1) % 7;
        tmo = old_play && (PLAY_MS != 0) && (m_age == T_OUT);
        if (!old_play) begin
            if (play_e) begin
                m_play = 1; m_phase = 0; m_age = 0;
                m_p = period_of(m_tone); m_c = high_of(m_tone, m_duty);
            end
        end else if (play_e || tmo) begin
            m_play = 0; m_phase = 0; m_age = 0;
        end else begin
            m_age   = (duty_e || tone_e) ? 0 : m_age + 1;
            m_phase = m_phase + 1;
            if (m_phase == m_p) begin
                m_phase = 0;
                m_p = period_of(m_tone); m_c = high_of(m_tone, m_duty);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model", {bus.beep, bus.playing, bus.tone_idx, bus.duty_sel},
                  {m_beep, m_play, 3'(m_tone), 2'(m_duty)});
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------------
    task automatic key(input logic [2:0] kv);
        bus.key_flag  = 1'b1;
        bus.key_value = kv;
        @(negedge clk);
        bus.key_flag  = 1'b0;
        bus.key_value = 3'b111;
    endtask

    task automatic wait_beep(input logic lvl, input int budget, input string tag, output int t);
        bit ok = 0;
        for (int i = 0; i <= budget; i++) begin
            if (bus.beep === lvl) begin ok = 1; break; end
            @(negedge clk);
        end
        t = cyc;
        check(tag, ok, 1);
    endtask

    task automatic wait_play(input logic lvl, input int budget, input string tag, output int t);
        bit ok = 0;
        for (int i = 0; i <= budget; i++) begin
            if (bus.playing === lvl) begin ok = 1; break; end
            @(negedge clk);
        end
        t = cyc;
        check(tag, ok, 1);
    endtask

    // Measures the next complete beep period, from rise to rise, and its
    // high time.
    task automatic measure(output int per_c, output int hi_c);
        int t0, t1, t2, tx;
        wait_beep(1'b0, 2000, "meas_low0", tx);
        wait_beep(1'b1, 2000, "meas_rise0", t0);
        wait_beep(1'b0, 2000, "meas_fall", t1);
        wait_beep(1'b1, 2000, "meas_rise1", t2);
        hi_c  = t1 - t0;
        per_c = t2 - t0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int per_c, hi_c, t0, t1, t_e, t_f, d, tx, highs;
        int exp_tone, exp_duty;
        logic [2:0] burst [4];

        bus.key_flag  = 1'b0;
        bus.key_value = 3'b111;
        repeat (3) @(negedge clk);
        check("reset_hold", {bus.beep, bus.playing, bus.tone_idx, bus.duty_sel}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {bus.beep, bus.playing, bus.tone_idx, bus.duty_sel}, 0);
        model_on = 1;
        exp_tone = 0;
        exp_duty = 0;

        // Start play: tone 0, duty 0.
        key(3'b011);
        check("play_on", bus.playing, 1);
        check("play_on_beep_late", bus.beep, 0);
        measure(per_c, hi_c);
        check("p0_period", per_c, period_of(0));
        check("p0_high", hi_c, high_of(0, 0));

        // A tone change in the middle of a period finishes the old period
        // first; the next period uses the new tone.
        wait_beep(1'b0, 2000, "mid_low", tx);
        wait_beep(1'b1, 2000, "mid_rise", t0);
        repeat (100) @(negedge clk);
        key(3'b110);
        exp_tone = 1;
        check("mid_tone", bus.tone_idx, exp_tone);
        wait_beep(1'b0, 2000, "mid_fall", tx);
        wait_beep(1'b1, 2000, "mid_rise2", t1);
        check("mid_old_period", t1 - t0, period_of(0));
        wait_beep(1'b0, 2000, "mid_fall2", tx);
        check("mid_new_high", tx - t1, high_of(1, 0));
        wait_beep(1'b1, 2000, "mid_rise3", t0);
        check("mid_new_period", t0 - t1, period_of(1));

        // Tone wraps 6 -> 0; duty wraps 3 -> 0.
        for (int i = 0; i < 13; i++) begin
            key(3'b110);
            exp_tone = (exp_tone + 1) % 7;
            check("tone_step", bus.tone_idx, exp_tone);
        end
        for (int i = 0; i < 6; i++) begin
            key(3'b101);
            exp_duty = (exp_duty + 1) % 4;
            check("duty_step", bus.duty_sel, exp_duty);
        end
        measure(per_c, hi_c);
        check("t0d2_period", per_c, period_of(0));
        check("t0d2_high", hi_c, high_of(0, 2));

        // Back-to-back key events, one per cycle: none may be dropped.
        burst[0] = 3'b110; burst[1] = 3'b110; burst[2] = 3'b101; burst[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            bus.key_flag  = 1'b1;
            bus.key_value = burst[i];
            @(negedge clk);
        end
        bus.key_flag  = 1'b0;
        bus.key_value = 3'b111;
        exp_tone = (exp_tone + 3) % 7;
        exp_duty = (exp_duty + 1) % 4;
        check("burst_tone", bus.tone_idx, exp_tone);
        check("burst_duty", bus.duty_sel, exp_duty);

        // All keys pressed: only the play toggle takes effect.
        key(3'b000);
        check("all_keys_stop", bus.playing, 0);
        check("all_keys_tone", bus.tone_idx, exp_tone);
        check("all_keys_duty", bus.duty_sel, exp_duty);
        @(negedge clk);
        check("stop_beep_off", bus.beep, 0);
        key(3'b111);
        check("release_noop", {bus.beep, bus.playing, bus.tone_idx, bus.duty_sel},
              {1'b0, 1'b0, 3'(exp_tone), 2'(exp_duty)});

        // Timeout with no keys pressed.
        key(3'b011);
        t_e = cyc;
        check("to_enter", bus.playing, 1);
        wait_play(1'b0, T_OUT + 10, "to_fall_seen", t_f);
        d = t_f - t_e;
        check("to_delay", (d >= T_OUT - 1 && d <= T_OUT + 1) ? T_OUT : d, T_OUT);
        @(negedge clk);
        check("to_beep_off", bus.beep, 0);

        // A duty event part-way through restarts the timeout.
        key(3'b011);
        t_e = cyc;
        while (cyc < t_e + int'(T_OUT * 3 / 5) - 1) @(negedge clk);
        key(3'b101);
        exp_duty = (exp_duty + 1) % 4;
        wait_play(1'b0, 2 * T_OUT, "to2_fall_seen", t_f);
        d = t_f - t_e;
        check("to2_delay",
              (d >= int'(T_OUT * 8 / 5) - 1 && d <= int'(T_OUT * 8 / 5) + 1) ? int'(T_OUT * 8 / 5) : d,
              T_OUT * 8 / 5);

        // Asynchronous reset asserted while beep is high.
        key(3'b110);
        key(3'b011);
        wait_beep(1'b1, 2000, "rst_rise", tx);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {bus.beep, bus.playing, bus.tone_idx, bus.duty_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.beep || bus.playing) highs++;
        end
        check("rst_stays_idle", highs, 0);

        // Randomized key traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            int gap, len;
            gap = ($urandom_range(0, 99) < 1) ? int'(T_OUT + 50) : int'($urandom_range(0, 25));
            repeat (gap) @(negedge clk);
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
                bus.key_flag  = 1'b1;
                bus.key_value = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(0, 3))
                                                          : 3'($urandom_range(4, 7));
                @(negedge clk);
            end
            bus.key_flag  = 1'b0;
            bus.key_value = 3'b111;
        end
        repeat (50) @(negedge clk);

        model_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/buzzer_key_ctrl.md
# buzzer_key_ctrl

Key-driven PWM buzzer controller: consumes the one-cycle debounced key event (key_flag + 3-bit active-low key_value) from the key debounce stage and drives the passive buzzer pin. Selects one of seven musical tones, one of four duty levels (volume), and toggles play/stop. Playback auto-stops after a programmable timeout. Sits directly downstream of the debouncer, between it and the buzzer pad.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz; tone periods and ms prescaler derive from it.
- PLAY_MS, 5000: auto-stop timeout in ms (16-bit); 0 disables timeout.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_flag  in  1  one-cycle strobe: key_value valid and stable
- key_value  in  3  debounced key levels, 0 = pressed; sampled only when key_flag=1
- beep  out  1  PWM drive to buzzer, 1 = driven
- playing  out  1  1 while FSM in PLAY
- tone_idx  out  3  current tone 0..6 (C4..B4)
- duty_sel  out  2  current duty level 0..3

## Operation
- Reset values: beep=0, playing=0, tone_idx=0, duty_sel=0, FSM=IDLE, all counters 0.
- Key decode, only on key_flag=1: key_value=3'b111 (release) ignored. Otherwise exactly one action, priority key[2] > key[1] > key[0]:
  - key[2] low: toggle play/stop (IDLE->PLAY, PLAY->IDLE).
  - key[1] low: duty_sel <= duty_sel+1, wraps 3->0.
  - key[0] low: tone_idx <= tone_idx+1, wraps 6->0.
- tone_idx/duty_sel change in IDLE and PLAY alike.
- Tone period table, P = CLK_FREQ/f (integer division); at 50 MHz: 0:262 Hz 190839, 1:294 Hz 170068, 2:330 Hz 151515, 3:349 Hz 143266, 4:392 Hz 127551, 5:440 Hz 113636, 6:494 Hz 101214. Counter width 18 bits minimum.
- Duty compare C = P >> (duty_sel+1): 50%, 25%, 12.5%, 6.25%.
- FSM states: IDLE (beep=0, pwm counter held at 0), PLAY (PWM runs). Transitions: IDLE->PLAY on key[2] event; PLAY->IDLE on key[2] event or timeout.
- PWM: counter cnt counts 0..P_act-1, wraps to 0. Shadow registers P_act/C_act load from table on entry to PLAY and at every wrap (cnt==P_act-1); mid-period tone/duty changes take effect at next period start only (no glitch, no short period).
- beep registered: beep <= (FSM==PLAY) && (cnt < C_act).
- Timeout: ms prescaler counts CLK_FREQ/1000 cycles per ms tick; ms_cnt increments per tick in PLAY. ms_cnt==PLAY_MS -> IDLE. Prescaler and ms_cnt clear on entering PLAY and on every accepted tone/duty event while in PLAY; held at 0 in IDLE.
- Timeout and key[2] event in same cycle: result IDLE (single transition, no re-entry).

## Timing
- key_flag high at edge E0: tone_idx/duty_sel/playing update at E0 (visible after E0).
- Entry to PLAY at E0: cnt=0 after E0; beep rises at E1 (one clock after playing).
- Stop at E0: playing falls after E0; beep falls after E1; cnt cleared after E0.
- Beep period exactly P_act cycles, high time exactly C_act cycles, first period included.
- Timeout: playing falls PLAY_MS*(CLK_FREQ/1000) cycles (±1) after the last PLAY entry or accepted key event.
- rst_n asserted mid-PLAY: all outputs to reset values immediately (asynchronous); after release, block idles until next key[2] event.
- Back-to-back key_flag pulses (every cycle) each processed; no event dropped.

## Test plan
- Reset, then key_flag with key_value=3'b011 -> playing=1 next cycle; beep period 190839 cycles, high 95419 cycles.
- In PLAY, key_value=3'b110 mid-period -> tone_idx=1; current period completes at 190839, next period 170068, high 85034.
- Seven key[0] events -> tone_idx 1,2,3,4,5,6,0; four key[1] events -> duty_sel 1,2,3,0; with tone 0, duty_sel=2 -> high 23854 cycles.
- key_value=3'b000 on key_flag -> only play toggles; tone_idx/duty_sel unchanged. key_value=3'b111 -> no change at all.
- PLAY_MS=2: enter PLAY, no keys -> playing falls after 100000 cycles (±1), beep 0 one cycle later; key[1] event at cycle 60000 -> timeout moves to 160000.
- rst_n pulsed low mid-high-phase of beep -> beep=0, playing=0, tone_idx=0, duty_sel=0 immediately; no beep after release until key[2] event.
